// File: rtl/sa9_fanin_arbiter.sv
// sa9_fanin_arbiter: round-robin fan-in of NUM_CHILD child beat streams into
// one upstream stream tagged with the source child index. A 2-entry buffer
// sits between the arbiter and the upstream port, so child handshakes never
// depend on out_ready.
// Optional feature: define FANIN_LOCK_EN to lock the grant to one child from
// its first beat until its in_last beat (packet lock).
module sa9_fanin_arbiter #(
    parameter int NUM_CHILD = 5,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_CHILD-1:0]        in_valid,
    output logic [NUM_CHILD-1:0]        in_ready,
    input  logic [NUM_CHILD*DATA_W-1:0] in_data,
    input  logic [NUM_CHILD-1:0]        in_last,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_last,
    output logic [ID_W-1:0]             out_id,
    output logic [15:0]                 beat_cnt
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              last;
        logic [ID_W-1:0]   id;
    } beat_t;

    // head_q is the entry shown upstream; tail_q is the second slot.
    // head_q is not cleared on pop, so outputs hold their last value when empty.
    beat_t           head_q, tail_q, in_beat;
    logic [1:0]      count;
    logic [ID_W-1:0] ptr_q, gnt;
    logic            gnt_ok, space, push, pop;

`ifdef FANIN_LOCK_EN
    logic            lock_vld;
    logic [ID_W-1:0] lock_id;
`endif

    assign space = (count < 2'd2);
    // rst_n gates push so in_ready stays low while reset is held
    assign push  = gnt_ok && space && rst_n;
    assign pop   = out_valid && out_ready;

    // Grant: locked child if a packet is open, else first valid child after ptr
    always_comb begin
        int idx;
        gnt_ok = 1'b0;
        gnt    = ptr_q;
        idx    = 0;
`ifdef FANIN_LOCK_EN
        if (lock_vld) begin
            gnt    = lock_id;
            gnt_ok = in_valid[lock_id];
        end else begin
`endif
            for (int k = 1; k <= NUM_CHILD; k++) begin
                idx = (int'(ptr_q) + k) % NUM_CHILD;
                if (!gnt_ok && in_valid[idx]) begin
                    gnt_ok = 1'b1;
                    gnt    = ID_W'(idx);
                end
            end
`ifdef FANIN_LOCK_EN
        end
`endif
    end

    // One-hot ready to the granted child while the buffer has room
    always_comb begin
        in_ready = '0;
        if (push) in_ready[gnt] = 1'b1;
    end

    // Beat captured from the granted child
    always_comb begin
        in_beat.data = in_data[gnt*DATA_W +: DATA_W];
        in_beat.last = in_last[gnt];
        in_beat.id   = gnt;
    end

    // Buffer, round-robin pointer and upstream beat counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q   <= '0;
            tail_q   <= '0;
            count    <= 2'd0;
            ptr_q    <= ID_W'(NUM_CHILD - 1);
            beat_cnt <= 16'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head_q <= in_beat;
                    else               tail_q <= in_beat;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    if (count == 2'd2) head_q <= tail_q;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    // count stays; push implies count<2, so only count==1 here
                    head_q <= in_beat;
                end
                default: ;
            endcase
            if (pop)  beat_cnt <= beat_cnt + 16'd1;
            if (push) ptr_q    <= gnt;
        end
    end

`ifdef FANIN_LOCK_EN
    // Packet lock: open on a non-last beat, close on the last beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_vld <= 1'b0;
            lock_id  <= '0;
        end else if (push) begin
            lock_vld <= !in_beat.last;
            lock_id  <= gnt;
        end
    end
`endif

    assign out_valid = (count != 2'd0);
    assign out_data  = head_q.data;
    assign out_last  = head_q.last;
    assign out_id    = head_q.id;

endmodule
